seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 95 +++++++++
 tb/tb_seq_detect_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector: shifts in qualified bits and pulses y one cycle after
// the last LEN valid bits equal PATTERN, with optional overlap and a saturating hit counter.
module seq_detect_param #(
  parameter int              LEN     = 6,
  parameter logic [LEN-1:0]  PATTERN = 6'b111010,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clear,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(LEN - 1);

  generate
    if (LEN < 2 || LEN > 32) begin : g_bad_len
      $error("seq_detect_param: LEN=%0d outside 2..32", LEN);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("seq_detect_param: CNT_W=%0d outside 1..32", CNT_W);
    end
  endgenerate

  logic [LEN-1:0]    hist_reg, hist_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              y_reg;
  logic [LEN-1:0]    window;
  logic              match;

  // Candidate history after this edge: newest LEN-1 stored bits with x appended.
  genvar gi;
  generate
    for (gi = 0; gi < LEN; gi++) begin : g_window
      if (gi == 0) begin : g_lsb
        assign window[gi] = x;
      end else begin : g_hist
        assign window[gi] = hist_reg[gi-1];
      end
    end
  endgenerate

  // The oldest history bit falls out of every compare window.
  logic unused_hist_msb;
  assign unused_hist_msb = hist_reg[LEN-1];

  assign match = x_valid && !clear && (fill_reg >= FILL_ARM) && (window == PATTERN);

  always_comb begin
    hist_next = hist_reg;
    fill_next = fill_reg;
    cnt_next  = cnt_reg;
    if (clear) begin
      hist_next = '0;
      fill_next = '0;
      cnt_next  = '0;
    end else if (x_valid) begin
      hist_next = window;
      fill_next = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
      if (match) begin
        if (OVERLAP == 1'b0) begin
          fill_next = '0;
        end
        if (cnt_reg != {CNT_W{1'b1}}) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '0;
      fill_reg <= '0;
      cnt_reg  <= '0;
      y_reg    <= 1'b0;
    end else begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      cnt_reg  <= cnt_next;
      y_reg    <= match;
    end
  end

  assign y         = y_reg;
  assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed check of four seq_detect_param configurations driven by a shared
// bit stream, each compared against a queue-based model of the valid-bit sequence.
module tb_seq_detect_param;

  localparam int NM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0;
  logic x_valid = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic       y0, y1, y2, y3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  // 0: defaults, 1: LEN=4 1010 overlap, 2: LEN=4 1010 non-overlap, 3: defaults with CNT_W=2
  seq_detect_param dut0 (.clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .clear(clear),
                         .y(y0), .match_cnt(c0));
  seq_detect_param #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .clear(clear), .y(y1), .match_cnt(c1));
  seq_detect_param #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .clear(clear), .y(y2), .match_cnt(c2));
  seq_detect_param #(.CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .clear(clear), .y(y3), .match_cnt(c3));

  int yv[NM];
  int cv[NM];
  assign yv[0] = int'(y0);
  assign yv[1] = int'(y1);
  assign yv[2] = int'(y2);
  assign yv[3] = int'(y3);
  assign cv[0] = int'(c0);
  assign cv[1] = int'(c1);
  assign cv[2] = int'(c2);
  assign cv[3] = int'(c3);

  int m_len[NM] = '{6, 4, 4, 6};
  int m_pat[NM] = '{32'b111010, 32'b1010, 32'b1010, 32'b111010};
  bit m_ovl[NM] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int m_cw[NM]  = '{8, 8, 8, 2};

  bit mq[NM][$];
  int m_cnt[NM];
  int m_y[NM];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NM; k++) begin
      mq[k].delete();
      m_cnt[k] = 0;
      m_y[k] = 0;
    end
  endfunction

  // Detection = the most recent LEN valid bits since the last restart spell PATTERN.
  function automatic void model_edge(input bit xb, input bit v, input bit clr);
    for (int k = 0; k < NM; k++) begin
      m_y[k] = 0;
      if (clr) begin
        mq[k].delete();
        m_cnt[k] = 0;
      end else if (v) begin
        bit hit;
        int n;
        int pat;
        mq[k].push_back(xb);
        if (mq[k].size() > m_len[k]) void'(mq[k].pop_front());
        n = mq[k].size();
        pat = m_pat[k];
        hit = (n == m_len[k]);
        for (int i = 0; i < m_len[k] && hit; i++)
          if (mq[k][n - m_len[k] + i] != pat[m_len[k] - 1 - i]) hit = 0;
        if (hit) begin
          m_y[k] = 1;
          if (m_cnt[k] < (1 << m_cw[k]) - 1) m_cnt[k]++;
          if (!m_ovl[k]) mq[k].delete();
        end
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < NM; k++) begin
      check($sformatf("y%0d", k), yv[k], m_y[k]);
      check($sformatf("cnt%0d", k), cv[k], m_cnt[k]);
    end
  endtask

  task automatic cycle(input bit xb, input bit v, input bit clr);
    @(negedge clk);
    x = xb;
    x_valid = v;
    clear = clr;
    @(posedge clk);
    #1;
    if (rst_n) model_edge(xb, v, clr);
    else model_reset();
    check_all();
    x_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic send(input bit b, input int gaps);
    cycle(b, 1'b1, 1'b0);
    repeat (gaps) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic send_pat(input int pat, input int len, input int gaps);
    for (int i = len - 1; i >= 0; i--) send(1'((pat >> i) & 1), gaps);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic pattern, then a leading extra 1
    send_pat(32'b111010, 6, 0);
    check("basic_cnt", cv[0], 1);
    cycle(1'b0, 1'b0, 1'b1);
    send_pat(32'b1111010, 7, 0);
    check("lead1_cnt", cv[0], 1);

    // Overlapping vs non-overlapping 1010 detection
    cycle(1'b0, 1'b0, 1'b1);
    send_pat(32'b1010101, 7, 0);
    check("ovl_cnt", cv[1], 2);
    check("novl_cnt", cv[2], 1);

    // Invalid gaps with x toggling
    cycle(1'b0, 1'b0, 1'b1);
    send_pat(32'b111010, 6, 3);
    check("gap_cnt", cv[0], 1);

    // Mid-stream asynchronous reset
    cycle(1'b0, 1'b0, 1'b1);
    send_pat(32'b11101, 5, 0);
    async_reset();
    send(1'b0, 0);
    check("rst_cnt", cv[0], 0);

    // Counter saturation with CNT_W=2
    cycle(1'b0, 1'b0, 1'b1);
    repeat (5) send_pat(32'b111010, 6, 0);
    check("sat_cnt", cv[3], 3);
    check("unsat_cnt", cv[0], 5);

    // Clear on the completing edge wins
    cycle(1'b0, 1'b0, 1'b1);
    send_pat(32'b111010, 6, 0);
    send_pat(32'b111010, 6, 0);
    send_pat(32'b11101, 5, 0);
    cycle(1'b0, 1'b1, 1'b1);
    check("clr_y", yv[0], 0);
    check("clr_cnt", cv[0], 0);
    send_pat(32'b111010, 6, 0);

    // Random traffic with occasional clear, reset and embedded patterns
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 3) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      else if (r < 5) async_reset();
      else if (r < 15) send_pat(32'b111010, 6, $urandom_range(0, 2));
      else cycle(1'($urandom_range(0, 1)), r < 150, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
